// File: rtl/race_link_ctrl.sv
// Ethernet link sequencer for the racing game: per-frame state snapshots and one-shot events
// share a single transmitter; received words are decoded into the opponent view and link health.
module race_link_ctrl #(
    parameter int START_TIMEOUT       = 64,
    parameter int LINK_TIMEOUT_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        vsync_in,
    input  logic [10:0] player_x_in,
    input  logic [10:0] player_y_in,
    input  logic [8:0]  direction_in,
    input  logic        evt_valid_in,
    input  logic [3:0]  evt_code_in,
    output logic        evt_ready_out,
    input  logic        tx_busy_in,
    input  logic        tx_done_in,
    output logic        tx_start_out,
    output logic [31:0] tx_payload_out,
    input  logic        rx_valid_in,
    input  logic [31:0] rx_data_in,
    output logic [10:0] opp_x_out,
    output logic [10:0] opp_y_out,
    output logic [8:0]  opp_dir_out,
    output logic        opp_evt_valid_out,
    output logic [3:0]  opp_evt_code_out,
    output logic        link_up_out,
    output logic [7:0]  evt_seq_out
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int FW = $clog2(LINK_TIMEOUT_FRAMES + 1);
    localparam logic [TW-1:0] TO_LAST      = TW'(START_TIMEOUT - 1);
    localparam logic [FW-1:0] FRAMES_MAX   = FW'(LINK_TIMEOUT_FRAMES);
    localparam logic [FW-1:0] FRAMES_LAST  = FW'(LINK_TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    tx_state_t      state;
    logic           vsync_q;
    logic           vsync_rise;
    logic [10:0]    snap_x;
    logic [10:0]    snap_y;
    logic [8:0]     snap_dir;
    logic           state_pend;
    logic           state_rearm;
    logic           evt_pend;
    logic [3:0]     evt_code_q;
    logic           serving_evt;
    logic [TW-1:0]  to_cnt;
    logic           evt_accept;
    logic           tx_complete;
    logic           state_load;
    logic           state_in_flight;
    logic           rx_hit;
    logic [7:0]     last_seq;
    logic [FW-1:0]  frame_cnt;

    assign vsync_rise      = vsync_in & ~vsync_q;
    assign evt_accept      = evt_valid_in & evt_ready_out;
    assign tx_complete     = tx_done_in & ((state == WAIT_BUSY) | (state == WAIT_DONE));
    assign state_load      = (state == IDLE) & ~evt_pend & state_pend;
    assign state_in_flight = (state != IDLE) & ~serving_evt;
    assign rx_hit          = rx_valid_in & (rx_data_in != '0);

    // Frame snapshot. A vsync that lands while a state packet is loading or in flight
    // re-arms the flag so the newer snapshot still goes out after the current one.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vsync_q     <= 1'b0;
            snap_x      <= '0;
            snap_y      <= '0;
            snap_dir    <= '0;
            state_pend  <= 1'b0;
            state_rearm <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_rise) begin
                snap_x   <= player_x_in;
                snap_y   <= player_y_in;
                snap_dir <= direction_in;
            end
            if (vsync_rise)
                state_pend <= 1'b1;
            else if (tx_complete && !serving_evt)
                state_pend <= state_rearm;
            if (tx_complete && !serving_evt)
                state_rearm <= 1'b0;
            else if (vsync_rise && (state_load || state_in_flight))
                state_rearm <= 1'b1;
        end
    end

    // Single-entry event holding register and local sequence number.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            evt_pend      <= 1'b0;
            evt_ready_out <= 1'b0;
            evt_code_q    <= '0;
            evt_seq_out   <= '0;
        end else begin
            if (evt_accept) begin
                evt_pend      <= 1'b1;
                evt_ready_out <= 1'b0;
                evt_code_q    <= evt_code_in;
            end else if (tx_complete && serving_evt) begin
                evt_pend      <= 1'b0;
                evt_ready_out <= 1'b1;
                evt_seq_out   <= evt_seq_out + 8'd1;
            end else begin
                evt_ready_out <= ~evt_pend;
            end
        end
    end

    // Transmit sequencer; the payload register is only reloaded from IDLE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            tx_start_out   <= 1'b0;
            tx_payload_out <= '0;
            to_cnt         <= '0;
            serving_evt    <= 1'b0;
        end else begin
            tx_start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt_pend) begin
                        tx_payload_out <= {1'b1, evt_code_q, evt_seq_out, 19'd0};
                        serving_evt    <= 1'b1;
                        tx_start_out   <= 1'b1;
                        state          <= LAUNCH;
                    end else if (state_pend) begin
                        tx_payload_out <= {1'b0, snap_x, snap_y, snap_dir};
                        serving_evt    <= 1'b0;
                        tx_start_out   <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    to_cnt <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_done_in) begin
                        state <= IDLE;
                    end else if (tx_busy_in) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        tx_start_out <= 1'b1;
                        state        <= LAUNCH;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_in)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receive decode and link watchdog; a valid word beats a same-cycle vsync.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            opp_x_out         <= '0;
            opp_y_out         <= '0;
            opp_dir_out       <= '0;
            opp_evt_valid_out <= 1'b0;
            opp_evt_code_out  <= '0;
            last_seq          <= 8'hFF;
            frame_cnt         <= '0;
            link_up_out       <= 1'b0;
        end else begin
            opp_evt_valid_out <= 1'b0;
            if (rx_hit) begin
                if (!rx_data_in[31]) begin
                    opp_x_out   <= rx_data_in[30:20];
                    opp_y_out   <= rx_data_in[19:9];
                    opp_dir_out <= rx_data_in[8:0];
                end else if (rx_data_in[26:19] != last_seq) begin
                    opp_evt_valid_out <= 1'b1;
                    opp_evt_code_out  <= rx_data_in[30:27];
                    last_seq          <= rx_data_in[26:19];
                end
            end
            if (rx_hit) begin
                frame_cnt   <= '0;
                link_up_out <= 1'b1;
            end else if (vsync_rise) begin
                if (frame_cnt != FRAMES_MAX)
                    frame_cnt <= frame_cnt + FW'(1);
                if (frame_cnt >= FRAMES_LAST)
                    link_up_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_race_link_ctrl.sv
// Self-checking bench for race_link_ctrl: launch scoreboard, rx decode vector table,
// and hand-written sequences for relaunch, link timeout and reset mid-send.
module tb_race_link_ctrl;

    localparam int TB_START_TIMEOUT = 64;
    localparam int TB_LINK_FRAMES   = 30;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        vsync_in = 1'b0;
    logic [10:0] player_x_in = '0;
    logic [10:0] player_y_in = '0;
    logic [8:0]  direction_in = '0;
    logic        evt_valid_in = 1'b0;
    logic [3:0]  evt_code_in = '0;
    logic        evt_ready_out;
    logic        tx_busy_in = 1'b0;
    logic        tx_done_in = 1'b0;
    logic        tx_start_out;
    logic [31:0] tx_payload_out;
    logic        rx_valid_in = 1'b0;
    logic [31:0] rx_data_in = '0;
    logic [10:0] opp_x_out;
    logic [10:0] opp_y_out;
    logic [8:0]  opp_dir_out;
    logic        opp_evt_valid_out;
    logic [3:0]  opp_evt_code_out;
    logic        link_up_out;
    logic [7:0]  evt_seq_out;

    race_link_ctrl #(
        .START_TIMEOUT(TB_START_TIMEOUT),
        .LINK_TIMEOUT_FRAMES(TB_LINK_FRAMES)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in),
        .player_x_in(player_x_in), .player_y_in(player_y_in), .direction_in(direction_in),
        .evt_valid_in(evt_valid_in), .evt_code_in(evt_code_in), .evt_ready_out(evt_ready_out),
        .tx_busy_in(tx_busy_in), .tx_done_in(tx_done_in), .tx_start_out(tx_start_out),
        .tx_payload_out(tx_payload_out), .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in),
        .opp_x_out(opp_x_out), .opp_y_out(opp_y_out), .opp_dir_out(opp_dir_out),
        .opp_evt_valid_out(opp_evt_valid_out), .opp_evt_code_out(opp_evt_code_out),
        .link_up_out(link_up_out), .evt_seq_out(evt_seq_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int n_launch = 0;
    int exp_launch = 0;
    int start_cyc = 0;
    logic [31:0] tx_exp[$];

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic [10:0] ex;
        logic [10:0] ey;
        logic [8:0]  edir;
        logic        eevt;
        logic [3:0]  ecode;
    } rx_vec_t;

    rx_vec_t rx_tab[10];
    rx_vec_t rx_q[$];

    function automatic logic [31:0] st_word(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d);
        return {1'b0, x, y, d};
    endfunction

    function automatic logic [31:0] ev_word(input logic [3:0] code, input logic [7:0] seq);
        return {1'b1, code, seq, 19'd0};
    endfunction

    function automatic rx_vec_t mk(input logic vld, input logic [31:0] data, input logic [10:0] ex,
                                   input logic [10:0] ey, input logic [8:0] edir, input logic eevt,
                                   input logic [3:0] ecode);
        rx_vec_t v;
        v.vld = vld; v.data = data; v.ex = ex; v.ey = ey; v.edir = edir; v.eevt = eevt; v.ecode = ecode;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic expect_tx(input logic [31:0] p);
        tx_exp.push_back(p);
        exp_launch++;
    endtask

    // Launch monitor: every start pulse must match the next expected payload.
    always @(negedge clk_in) begin : tx_mon
        logic [31:0] e;
        if (tx_start_out === 1'b1) begin
            n_launch++;
            if (tx_exp.size() == 0) begin
                check("unexpected_launch", {31'd0, tx_start_out}, 32'd0);
            end else begin
                e = tx_exp.pop_front();
                check("launch_payload", tx_payload_out, e);
            end
        end
    end

    task automatic wait_start(input string name, input int budget);
        int waited;
        waited = 0;
        while (tx_start_out !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        check(name, {31'd0, tx_start_out}, 32'd1);
        start_cyc = cyc;
    endtask

    task automatic finish_tx(input int nb, input logic [31:0] p);
        tx_busy_in = (nb > 0);
        tick();
        check("start_pulse_width", {31'd0, tx_start_out}, 32'd0);
        for (int i = 1; i < nb; i++) tick();
        check("payload_stable", tx_payload_out, p);
        tx_busy_in = 1'b0;
        tx_done_in = 1'b1;
        tick();
        tx_done_in = 1'b0;
    endtask

    task automatic frame(input logic exp_link, input logic with_rx, input string nm);
        logic [31:0] p;
        p = st_word(player_x_in, player_y_in, direction_in);
        expect_tx(p);
        vsync_in = 1'b1;
        if (with_rx) begin
            rx_valid_in = 1'b1;
            rx_data_in  = st_word(11'd7, 11'd8, 9'd9);
        end
        tick();
        vsync_in    = 1'b0;
        rx_valid_in = 1'b0;
        rx_data_in  = '0;
        check(nm, {31'd0, link_up_out}, {31'd0, exp_link});
        wait_start("frame_start", 10);
        finish_tx(1, p);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] p;
        int c0;
        rx_vec_t e;

        rx_tab[0] = mk(1'b1, st_word(11'd320, 11'd320, 9'd90), 11'd320, 11'd320, 9'd90, 1'b0, 4'd0);
        rx_tab[1] = mk(1'b1, 32'd0,                            11'd320, 11'd320, 9'd90, 1'b0, 4'd0);
        rx_tab[2] = mk(1'b0, st_word(11'd1, 11'd1, 9'd1),      11'd320, 11'd320, 9'd90, 1'b0, 4'd0);
        rx_tab[3] = mk(1'b1, ev_word(4'd5, 8'd5),              11'd320, 11'd320, 9'd90, 1'b1, 4'd5);
        rx_tab[4] = mk(1'b1, ev_word(4'd7, 8'd5),              11'd320, 11'd320, 9'd90, 1'b0, 4'd0);
        rx_tab[5] = mk(1'b1, ev_word(4'd9, 8'd6),              11'd320, 11'd320, 9'd90, 1'b1, 4'd9);
        rx_tab[6] = mk(1'b1, st_word(11'd2047, 11'd0, 9'd359), 11'd2047, 11'd0, 9'd359, 1'b0, 4'd0);
        rx_tab[7] = mk(1'b1, ev_word(4'd1, 8'd255),            11'd2047, 11'd0, 9'd359, 1'b1, 4'd1);
        rx_tab[8] = mk(1'b1, ev_word(4'd2, 8'd255),            11'd2047, 11'd0, 9'd359, 1'b0, 4'd0);
        rx_tab[9] = mk(1'b1, ev_word(4'd3, 8'd5),              11'd2047, 11'd0, 9'd359, 1'b1, 4'd3);

        // Reset state
        repeat (3) tick();
        check("rst_tx_start", {31'd0, tx_start_out}, 32'd0);
        check("rst_payload", tx_payload_out, 32'd0);
        check("rst_evt_ready", {31'd0, evt_ready_out}, 32'd0);
        check("rst_link_up", {31'd0, link_up_out}, 32'd0);
        check("rst_evt_seq", {24'd0, evt_seq_out}, 32'd0);
        check("rst_opp_x", {21'd0, opp_x_out}, 32'd0);
        rst_in = 1'b0;
        tick();
        tick();
        check("ready_after_reset", {31'd0, evt_ready_out}, 32'd1);

        // Single frame: state packet, busy 10 cycles, done, no second launch
        player_x_in = 11'd191; player_y_in = 11'd191; direction_in = 9'd270;
        p = st_word(11'd191, 11'd191, 9'd270);
        check("state_word_model", p, 32'h0BF17F0E);
        expect_tx(p);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        wait_start("first_launch", 10);
        finish_tx(10, p);
        repeat (20) tick();
        check("single_launch_count", n_launch, exp_launch);

        // Event and vsync together: event first with seq 0, then state
        check("ready_before_evt", {31'd0, evt_ready_out}, 32'd1);
        player_x_in = 11'd100; player_y_in = 11'd200; direction_in = 9'd45;
        evt_valid_in = 1'b1; evt_code_in = 4'h3; vsync_in = 1'b1;
        expect_tx(32'h98000000);
        expect_tx(st_word(11'd100, 11'd200, 9'd45));
        tick();
        evt_valid_in = 1'b0; vsync_in = 1'b0;
        check("ready_low_when_pending", {31'd0, evt_ready_out}, 32'd0);
        wait_start("evt_launch", 10);
        finish_tx(4, 32'h98000000);
        check("evt_seq_after_evt", {24'd0, evt_seq_out}, 32'd1);
        check("ready_after_evt", {31'd0, evt_ready_out}, 32'd1);
        wait_start("state_after_evt", 10);
        finish_tx(4, st_word(11'd100, 11'd200, 9'd45));
        check("evt_state_launch_count", n_launch, exp_launch);

        // Busy never rises: relaunch every START_TIMEOUT+1 cycles
        player_x_in = 11'd5; player_y_in = 11'd6; direction_in = 9'd7;
        p = st_word(11'd5, 11'd6, 9'd7);
        repeat (3) expect_tx(p);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        wait_start("relaunch_first", 10);
        c0 = start_cyc;
        tick();
        wait_start("relaunch_second", TB_START_TIMEOUT + 20);
        check("relaunch_period_1", start_cyc - c0, TB_START_TIMEOUT + 1);
        c0 = start_cyc;
        tick();
        wait_start("relaunch_third", TB_START_TIMEOUT + 20);
        check("relaunch_period_2", start_cyc - c0, TB_START_TIMEOUT + 1);
        finish_tx(3, p);
        repeat (100) tick();
        check("relaunch_cleared", n_launch, exp_launch);

        // Done without busy completes the send
        player_x_in = 11'd1; player_y_in = 11'd2; direction_in = 9'd3;
        p = st_word(11'd1, 11'd2, 9'd3);
        expect_tx(p);
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        wait_start("done_first_launch", 10);
        finish_tx(0, p);
        repeat (TB_START_TIMEOUT + 16) tick();
        check("done_first_no_relaunch", n_launch, exp_launch);

        // Receive decode table
        check("link_down_before_rx", {31'd0, link_up_out}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            rx_valid_in = rx_tab[i].vld;
            rx_data_in  = rx_tab[i].data;
            rx_q.push_back(rx_tab[i]);
            tick();
            rx_valid_in = 1'b0;
            rx_data_in  = '0;
            e = rx_q.pop_front();
            check("opp_x", {21'd0, opp_x_out}, {21'd0, e.ex});
            check("opp_y", {21'd0, opp_y_out}, {21'd0, e.ey});
            check("opp_dir", {23'd0, opp_dir_out}, {23'd0, e.edir});
            check("opp_evt_valid", {31'd0, opp_evt_valid_out}, {31'd0, e.eevt});
            if (e.eevt) check("opp_evt_code", {28'd0, opp_evt_code_out}, {28'd0, e.ecode});
            if (i == 0) check("link_up_after_rx", {31'd0, link_up_out}, 32'd1);
            tick();
            check("opp_evt_pulse_width", {31'd0, opp_evt_valid_out}, 32'd0);
        end

        // Link timeout on the 30th silent vsync edge
        player_x_in = 11'd10; player_y_in = 11'd20; direction_in = 9'd30;
        for (int i = 0; i < TB_LINK_FRAMES; i++)
            frame(i < TB_LINK_FRAMES - 1, 1'b0, "link_timeout_edge");
        rx_valid_in = 1'b1;
        rx_data_in  = st_word(11'd7, 11'd8, 9'd9);
        tick();
        rx_valid_in = 1'b0;
        rx_data_in  = '0;
        check("link_recover", {31'd0, link_up_out}, 32'd1);
        check("recover_opp_x", {21'd0, opp_x_out}, 32'd7);

        // Same-cycle rx and vsync: rx clears the counter
        for (int i = 0; i < TB_LINK_FRAMES - 1; i++)
            frame(1'b1, 1'b0, "link_hold_edge");
        frame(1'b1, 1'b1, "rx_beats_vsync");
        frame(1'b1, 1'b0, "link_after_tie");
        check("link_launch_count", n_launch, exp_launch);

        // Reset during a send discards pending work
        check("ready_before_reset_evt", {31'd0, evt_ready_out}, 32'd1);
        evt_valid_in = 1'b1; evt_code_in = 4'hA;
        expect_tx(ev_word(4'hA, 8'd1));
        tick();
        evt_valid_in = 1'b0;
        wait_start("reset_evt_launch", 10);
        tx_busy_in = 1'b1;
        repeat (2) tick();
        rst_in = 1'b1;
        tx_busy_in = 1'b0;
        repeat (2) tick();
        check("midrst_tx_start", {31'd0, tx_start_out}, 32'd0);
        check("midrst_payload", tx_payload_out, 32'd0);
        check("midrst_evt_seq", {24'd0, evt_seq_out}, 32'd0);
        check("midrst_link", {31'd0, link_up_out}, 32'd0);
        check("midrst_opp_x", {21'd0, opp_x_out}, 32'd0);
        rst_in = 1'b0;
        repeat (2) tick();
        check("midrst_ready", {31'd0, evt_ready_out}, 32'd1);
        repeat (TB_START_TIMEOUT + 16) tick();
        check("midrst_no_launch", n_launch, exp_launch);
        check("tx_queue_drained", tx_exp.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
